// File: rtl/pfi_form.sv
`default_nettype none
// ============================================================================
// Module   : pfi_form
// Brief    : Element-granular join/pop formatter. Variable-size join beats
//            (1..MAX_ELEMS elements) are written into a circular element
//            store; variable-size pop beats are emitted in strict FIFO order
//            on a registered output word, oldest element in the lowest lane.
// Revision : 1.0 - initial release
// ============================================================================
module pfi_form #(
    parameter int ELEM_W    = 6,
    parameter int MAX_ELEMS = 32,
    parameter int DEPTH     = 64
) (
    input  logic                            i_core_clk,
    input  logic                            i_rx_rstn,   // active-high despite the name
    input  logic                            JoinEnable,
    output logic                            JoinPermit,
    input  logic [$clog2(MAX_ELEMS)-1:0]    JoinAmout,
    input  logic [ELEM_W*MAX_ELEMS-1:0]     JoinData,
    input  logic                            PopPermit,
    input  logic [$clog2(MAX_ELEMS)-1:0]    PopAmout,
    output logic [ELEM_W*MAX_ELEMS-1:0]     PopData,
    output logic                            PopEnable
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_WORD_W = ELEM_W * MAX_ELEMS;

    localparam logic [c_CNT_W-1:0] c_DEPTH_C = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_MAX_C   = c_CNT_W'(MAX_ELEMS);

    logic [ELEM_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_CNT_W-1:0]  w_join_n;
    logic [c_CNT_W-1:0]  w_pop_n;
    logic                w_join_fire;
    logic                w_pop_fire;
    logic [c_WORD_W-1:0] w_pop_data;

    // Amount fields encode count-1; widen before adding so 32 does not wrap
    assign w_join_n = c_CNT_W'(JoinAmout) + c_CNT_W'(1);
    assign w_pop_n  = c_CNT_W'(PopAmout)  + c_CNT_W'(1);

    // Permit only when a worst-case full beat fits, so a join never overflows
    assign JoinPermit  = ((c_DEPTH_C - r_count) >= c_MAX_C);
    assign w_join_fire = JoinEnable && JoinPermit;

    // Pop decision uses the pre-edge count, so it never sees same-cycle joins
    assign w_pop_fire  = PopPermit && (r_count >= w_pop_n);

    // Gather the oldest PopAmout+1 elements; unused upper lanes forced to zero.
    // A concurrent join writes only free slots, so these reads are unaffected.
    always_comb begin
        w_pop_data = '0;
        for (int j = 0; j < MAX_ELEMS; j++) begin
            if (j <= int'(PopAmout)) begin
                w_pop_data[j*ELEM_W +: ELEM_W] = r_mem[r_rptr + c_PTR_W'(j)];
            end
        end
    end

    // Element store: write the accepted lanes starting at the write pointer
    always_ff @(posedge i_core_clk) begin
        if (w_join_fire) begin
            for (int k = 0; k < MAX_ELEMS; k++) begin
                if (k <= int'(JoinAmout)) begin
                    r_mem[r_wptr + c_PTR_W'(k)] <= JoinData[k*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    // Pointers, occupancy and the registered pop output word
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rstn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            PopEnable <= 1'b0;
            PopData   <= '0;
        end else begin
            if (w_join_fire) begin
                r_wptr <= r_wptr + c_PTR_W'(w_join_n);
            end
            if (w_pop_fire) begin
                r_rptr  <= r_rptr + c_PTR_W'(w_pop_n);
                PopData <= w_pop_data;
            end
            PopEnable <= w_pop_fire;
            r_count   <= r_count
                       + (w_join_fire ? w_join_n : '0)
                       - (w_pop_fire  ? w_pop_n  : '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pfi_form.sv
`default_nettype none
// ============================================================================
// Module   : tb_pfi_form
// Brief    : Directed self-checking bench for pfi_form. A reference occupancy
//            count and element sequence numbers predict JoinPermit, pop firing
//            and every popped word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pfi_form;

    localparam int ELEM_W = 6;
    localparam int MAXE   = 32;
    localparam int DEPTH  = 64;
    localparam int WORD_W = ELEM_W * MAXE;

    logic              tb_sclk = 1'b0;
    logic              tb_rst;
    logic              join_enable;
    logic              join_permit;
    logic [4:0]        join_amount;
    logic [WORD_W-1:0] join_data;
    logic              pop_permit;
    logic [4:0]        pop_amount;
    logic [WORD_W-1:0] pop_data;
    logic              pop_enable;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int                m_count = 0;
    int                next_in = 0;
    int                exp_out = 0;
    logic [WORD_W-1:0] last_pd = '0;

    pfi_form #(.ELEM_W(ELEM_W), .MAX_ELEMS(MAXE), .DEPTH(DEPTH)) dut (
        .i_core_clk (tb_sclk),
        .i_rx_rstn  (tb_rst),
        .JoinEnable (join_enable),
        .JoinPermit (join_permit),
        .JoinAmout  (join_amount),
        .JoinData   (join_data),
        .PopPermit  (pop_permit),
        .PopAmout   (pop_amount),
        .PopData    (pop_data),
        .PopEnable  (pop_enable)
    );

    always #5 tb_sclk = ~tb_sclk;

    task automatic check(input string tag, input logic [WORD_W-1:0] obs,
                         input logic [WORD_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict, drive, step past the edge, compare registered outputs
    task automatic cycle(input bit jen, input int jn, input bit pp, input int pn);
        logic [WORD_W-1:0] jd;
        logic [WORD_W-1:0] exp_pd;
        bit jf;
        bit pf;
        check("join_permit", {191'd0, join_permit}, {191'd0, (DEPTH - m_count) >= MAXE});
        for (int k = 0; k < MAXE; k++) begin
            jd[k*ELEM_W +: ELEM_W] = (k < jn) ? 6'(next_in + k) : 6'($urandom);
        end
        join_enable = jen;
        join_amount = 5'(jn - 1);
        join_data   = jd;
        pop_permit  = pp;
        pop_amount  = 5'(pn - 1);
        jf = jen && ((DEPTH - m_count) >= MAXE);
        pf = pp && (m_count >= pn);
        @(posedge tb_sclk);
        #1;
        check("pop_enable", {191'd0, pop_enable}, {191'd0, pf});
        if (pf) begin
            exp_pd = '0;
            for (int j = 0; j < pn; j++) begin
                exp_pd[j*ELEM_W +: ELEM_W] = 6'(exp_out + j);
            end
            check("pop_data", pop_data, exp_pd);
            exp_out += pn;
            last_pd  = exp_pd;
        end else begin
            check("pop_hold", pop_data, last_pd);
        end
        m_count += (jf ? jn : 0) - (pf ? pn : 0);
        next_in += jf ? jn : 0;
    endtask

    task automatic do_reset(input int new_base);
        tb_rst = 1'b1;
        @(posedge tb_sclk);
        #1;
        tb_rst      = 1'b0;
        join_enable = 1'b0;
        pop_permit  = 1'b0;
        check("rst_pop_enable", {191'd0, pop_enable}, '0);
        check("rst_pop_data", pop_data, '0);
        check("rst_join_permit", {191'd0, join_permit}, {191'd0, 1'b1});
        m_count = 0;
        next_in = new_base;
        exp_out = new_base;
        last_pd = '0;
    endtask

    int jn_tab [7] = '{7, 19, 32, 16, 24, 7, 19};
    int pn_tab [7] = '{7, 19, 32, 16, 24, 19, 7};

    initial begin
        tb_rst      = 1'b1;
        join_enable = 1'b0;
        join_amount = '0;
        join_data   = '0;
        pop_permit  = 1'b0;
        pop_amount  = '0;
        repeat (2) @(posedge tb_sclk);
        #1;
        do_reset(0);

        // Pop requested on an empty store must not fire
        repeat (3) cycle(1'b0, 1, 1'b1, 1);

        // Fill with 10-element joins until JoinPermit drops at count 40
        repeat (6) cycle(1'b1, 10, 1'b0, 19);
        check("fill_count40_permit", {191'd0, join_permit}, '0);

        // Drain with 19-element pops while joins keep offering
        repeat (6) cycle(1'b1, 10, 1'b1, 19);

        // Change sizes mid-stream
        repeat (20) cycle(1'b1, 19, 1'b1, 10);

        // Fixed join/pop size mixes across many pointer wraps
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 260; i++) begin
                cycle($urandom_range(0, 7) != 0, jn_tab[c],
                      $urandom_range(0, 7) != 0, pn_tab[c]);
            end
        end

        // Sizes changing every cycle
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(1, 32),
                  $urandom_range(0, 3) != 0, $urandom_range(1, 32));
        end

        // Reset with 25 stored elements and a pop that would otherwise fire
        do_reset(40);
        cycle(1'b1, 25, 1'b0, 10);
        join_enable = 1'b0;
        pop_permit  = 1'b1;
        pop_amount  = 5'd9;
        do_reset(0);

        // Fresh stream: empty-store pop refused, then data restarts at 0
        cycle(1'b0, 1, 1'b1, 10);
        cycle(1'b1, 12, 1'b1, 10);
        repeat (40) cycle(1'b1, 12, 1'b1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
